text_sequencer: RTL and testbench

TEXT_SEQUENCER -- requirements
Module: text_sequencer

---
 rtl/text_sequencer_if.sv | 28 ++
 rtl/text_sequencer.sv | 126 ++++++++++++
 tb/tb_text_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/text_sequencer_if.sv
// Bundle of message-control, glyph-ROM and framebuffer-write signals for text_sequencer.
// master is the sequencer side; slave is the integrator (ROM + framebuffer) side.
interface text_sequencer_if #(
    parameter int unsigned GLYPH_W = 20
);
    logic               start;
    logic [1:0]         msg_sel;
    logic [7:0]         char_code;
    logic [2:0]         row_sel;
    logic [GLYPH_W-1:0] rom_row;
    logic               wr_valid;
    logic               wr_ready;
    logic [2:0]         wr_x;
    logic [2:0]         wr_y;
    logic [GLYPH_W-1:0] wr_data;
    logic               busy;
    logic               done;

    modport master (
        input  start, msg_sel, rom_row, wr_ready,
        output char_code, row_sel, wr_valid, wr_x, wr_y, wr_data, busy, done
    );

    modport slave (
        output start, msg_sel, rom_row, wr_ready,
        input  char_code, row_sel, wr_valid, wr_x, wr_y, wr_data, busy, done
    );
endinterface

// File: rtl/text_sequencer.sv
// Walks a fixed message character by character and row by row, fetching each glyph
// row from an external ROM and handing it to a framebuffer over a valid/ready write port.
module text_sequencer #(
    parameter int unsigned GLYPH_ROWS = 6,
    parameter int unsigned GLYPH_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    text_sequencer_if.master  bus
);
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(GLYPH_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [IDX_W-1:0]   char_idx_q, char_idx_d;
    logic [IDX_W-1:0]   row_idx_q, row_idx_d;
    logic [GLYPH_W-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0]   last_char;

    // ASCII lookup: 0 GUESS, 1 START, 2 PAUSED, 3 GREAT
    function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [IDX_W-1:0] idx);
        logic [7:0] c;
        c = 8'd0;
        case ({sel, idx})
            {2'd0, 3'd0}: c = 8'd71;
            {2'd0, 3'd1}: c = 8'd85;
            {2'd0, 3'd2}: c = 8'd69;
            {2'd0, 3'd3}: c = 8'd83;
            {2'd0, 3'd4}: c = 8'd83;
            {2'd1, 3'd0}: c = 8'd83;
            {2'd1, 3'd1}: c = 8'd84;
            {2'd1, 3'd2}: c = 8'd65;
            {2'd1, 3'd3}: c = 8'd82;
            {2'd1, 3'd4}: c = 8'd84;
            {2'd2, 3'd0}: c = 8'd80;
            {2'd2, 3'd1}: c = 8'd65;
            {2'd2, 3'd2}: c = 8'd85;
            {2'd2, 3'd3}: c = 8'd83;
            {2'd2, 3'd4}: c = 8'd69;
            {2'd2, 3'd5}: c = 8'd68;
            {2'd3, 3'd0}: c = 8'd71;
            {2'd3, 3'd1}: c = 8'd82;
            {2'd3, 3'd2}: c = 8'd69;
            {2'd3, 3'd3}: c = 8'd65;
            {2'd3, 3'd4}: c = 8'd84;
            default:      c = 8'd0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 2'd0;
            char_idx_q <= '0;
            row_idx_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            char_idx_q <= char_idx_d;
            row_idx_q  <= row_idx_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign last_char = (sel_q == 2'd2) ? IDX_W'(5) : IDX_W'(4);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        char_idx_d = char_idx_q;
        row_idx_d  = row_idx_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sel_d      = bus.msg_sel;
                    char_idx_d = '0;
                    row_idx_d  = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                wr_data_d = bus.rom_row;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                // Advance row first, then character; the last row of the last character ends the message
                if (bus.wr_ready) begin
                    if (row_idx_q != LAST_ROW) begin
                        row_idx_d = row_idx_q + IDX_W'(1);
                        state_d   = S_FETCH;
                    end else if (char_idx_q != last_char) begin
                        char_idx_d = char_idx_q + IDX_W'(1);
                        row_idx_d  = '0;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only
    assign bus.char_code = (state_q == S_FETCH || state_q == S_WRITE)
                         ? msg_char(sel_q, char_idx_q) : 8'd0;
    assign bus.row_sel   = row_idx_q;
    assign bus.wr_valid  = (state_q == S_WRITE);
    assign bus.wr_x      = char_idx_q;
    assign bus.wr_y      = row_idx_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_text_sequencer.sv
// Directed bench for text_sequencer with a behavioural glyph ROM and a write monitor.
module tb_text_sequencer;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   done_cnt;
    int   busy_cyc;
    logic [33:0] q[$];
    string msgs[4];

    text_sequencer_if #(.GLYPH_W(20)) bus ();

    text_sequencer #(.GLYPH_ROWS(6), .GLYPH_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] glyph(input logic [7:0] c, input logic [2:0] r);
        if (c == 8'd71 && r == 3'd0) return 20'b00000111111111100000;
        if (c == 8'd68 && r == 3'd5) return 20'b11111111111111100000;
        return {c, 1'b1, r, 8'h5A};
    endfunction

    always_comb bus.rom_row = glyph(bus.char_code, bus.row_sel);

    always @(posedge clk) begin
        if (bus.wr_valid && bus.wr_ready) q.push_back({bus.wr_x, bus.wr_y, bus.char_code, bus.wr_data});
        if (bus.done) done_cnt++;
        if (bus.busy && !bus.done) busy_cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input logic [1:0] sel);
        q.delete();
        done_cnt    = 0;
        busy_cyc    = 0;
        bus.msg_sel = sel;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic finish_msg(input int sel);
        int    n;
        bit    seen;
        string s;
        logic [7:0] c;
        s    = msgs[sel];
        n    = 0;
        seen = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (seen) break;
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_after_done", 64'(bus.busy), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        check("write_count", 64'(q.size()), 64'(s.len() * 6));
        for (int i = 0; i < q.size() && i < s.len() * 6; i++) begin
            c = s[i / 6];
            check($sformatf("wr%0d_msg%0d", i, sel), 64'(q[i]),
                  64'({3'(i / 6), 3'(i % 6), c, glyph(c, 3'(i % 6))}));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_wr_valid"},  64'(bus.wr_valid),  64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_done"},      64'(bus.done),      64'd0);
        check({tag, "_char_code"}, 64'(bus.char_code), 64'd0);
        check({tag, "_row_sel"},   64'(bus.row_sel),   64'd0);
        check({tag, "_wr_x"},      64'(bus.wr_x),      64'd0);
        check({tag, "_wr_y"},      64'(bus.wr_y),      64'd0);
        check({tag, "_wr_data"},   64'(bus.wr_data),   64'd0);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        done_cnt = 0;
        busy_cyc = 0;
        msgs[0] = "GUESS";
        msgs[1] = "START";
        msgs[2] = "PAUSED";
        msgs[3] = "GREAT";
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.msg_sel  = 2'd0;
        bus.wr_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // GUESS with ready tied high: latency, first row, cycle count
        bus.wr_ready = 1'b1;
        start_msg(2'd0);
        check("a_fetch_busy", 64'(bus.busy), 64'd1);
        check("a_fetch_valid", 64'(bus.wr_valid), 64'd0);
        check("a_fetch_code", 64'(bus.char_code), 64'd71);
        @(negedge clk);
        check("a_first_valid", 64'(bus.wr_valid), 64'd1);
        check("a_first_xy", 64'({bus.wr_x, bus.wr_y}), 64'd0);
        check("a_first_data", 64'(bus.wr_data), 64'(20'b00000111111111100000));
        finish_msg(0);
        check("a_busy_cycles", 64'(busy_cyc), 64'd60);

        // PAUSED: six characters, last row of 'D'
        start_msg(2'd2);
        finish_msg(2);
        if (q.size() > 0)
            check("b_last_write", 64'(q[q.size() - 1]), 64'({3'd5, 3'd5, 8'd68, 20'b11111111111111100000}));
        else
            check("b_last_write_present", 64'(q.size()), 64'd36);

        // GREAT with a 4-cycle stall at x=1,y=2
        start_msg(2'd3);
        n = 0;
        while (n < 200 && !(bus.wr_valid && bus.wr_x == 3'd1 && bus.wr_y == 3'd2)) begin
            @(negedge clk);
            n++;
        end
        check("c_stall_point_reached", 64'(n < 200), 64'd1);
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("c_stall%0d_valid", k), 64'(bus.wr_valid), 64'd1);
            check($sformatf("c_stall%0d_xyd", k), 64'({bus.wr_x, bus.wr_y, bus.wr_data}),
                  64'({3'd1, 3'd2, glyph(8'd82, 3'd2)}));
        end
        bus.wr_ready = 1'b1;
        finish_msg(3);

        // GUESS with start re-pulsed and msg_sel changed mid-message
        start_msg(2'd0);
        repeat (3) @(negedge clk);
        bus.msg_sel = 2'd3;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        repeat (5) @(negedge clk);
        bus.msg_sel = 2'd1;
        finish_msg(0);

        // Reset during WRITE at x=2,y=3, then restart with START
        start_msg(2'd0);
        n = 0;
        while (n < 200 && !(bus.wr_valid && bus.wr_x == 3'd2 && bus.wr_y == 3'd3)) begin
            @(negedge clk);
            n++;
        end
        check("d_abort_point_reached", 64'(n < 200), 64'd1);
        reset = 1'b1;
        #1;
        check_idle_zero("d_abort");
        repeat (3) @(negedge clk);
        check("d_writes_before_abort", 64'(q.size()), 64'd15);
        check("d_no_done", 64'(done_cnt), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        start_msg(2'd1);
        check("d_restart_code", 64'(bus.char_code), 64'd83);
        finish_msg(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
